// File: rtl/maze_memory.sv
// Maze cell store for the rat: host row-load port plus rat X/Y read/write.
// Optional MAZE_ACCESS_COUNT_EN adds saturating rd/wr access counters.
module maze_memory #(
  parameter int N = 4
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                Load_start,
  input  logic [(2**N)-1:0]   row_data,
  input  logic                row_valid,
  output logic                row_ready,
  output logic                Ready,
  input  logic [N-1:0]        X,
  input  logic [N-1:0]        Y,
  input  logic                RD,
  input  logic                WR,
  input  logic                D_in,
  output logic                D_out
`ifdef MAZE_ACCESS_COUNT_EN
  ,
  output logic [15:0]         rd_count,
  output logic [15:0]         wr_count
`endif
);

  localparam int ROWS = 2**N;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_READY = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ROWS-1:0]   r_mem [ROWS];
  logic [N-1:0]      r_row_cnt;
  logic              r_ready;
  logic              r_d_out;
  logic              w_row_ready;
  logic              w_accept;
  logic              w_last;
  logic              w_in_ready;

  assign w_accept   = row_valid & w_row_ready;
  assign w_last     = (r_row_cnt == N'(ROWS-1));
  assign w_in_ready = (r_state == S_READY);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (Load_start) w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        if (Load_start)
          w_state_nxt = S_LOAD;
        else if (w_accept && w_last)
          w_state_nxt = S_READY;
      end
      S_READY: begin
        if (Load_start) w_state_nxt = S_LOAD;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_row_ready = 1'b0;
    unique case (r_state)
      S_LOAD:  w_row_ready = 1'b1;
      default: w_row_ready = 1'b0;
    endcase
  end

  // Rat read samples the pre-write cell, so RD+WR on one cell is read-before-write.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < ROWS; i++) begin
        r_mem[i] <= '0;
      end
      r_row_cnt <= '0;
      r_ready   <= 1'b0;
      r_d_out   <= 1'b1;
    end else begin
      r_ready <= (w_state_nxt == S_READY);
      if (w_accept) begin
        r_mem[r_row_cnt] <= row_data;
      end
      if (Load_start) begin
        r_row_cnt <= '0;
      end else if (w_accept) begin
        r_row_cnt <= r_row_cnt + N'(1);
      end
      if (w_in_ready && WR) begin
        r_mem[Y][X] <= D_in;
      end
      if (RD) begin
        r_d_out <= w_in_ready ? r_mem[Y][X] : 1'b1;
      end
    end
  end

`ifdef MAZE_ACCESS_COUNT_EN
  logic [15:0] r_rd_cnt;
  logic [15:0] r_wr_cnt;

  always_ff @(posedge CLK) begin
    if (RST || Load_start) begin
      r_rd_cnt <= '0;
      r_wr_cnt <= '0;
    end else begin
      if (w_in_ready && RD && (r_rd_cnt != 16'hFFFF)) begin
        r_rd_cnt <= r_rd_cnt + 16'd1;
      end
      if (w_in_ready && WR && (r_wr_cnt != 16'hFFFF)) begin
        r_wr_cnt <= r_wr_cnt + 16'd1;
      end
    end
  end

  assign rd_count = r_rd_cnt;
  assign wr_count = r_wr_cnt;
`endif

  assign row_ready = w_row_ready;
  assign Ready     = r_ready;
  assign D_out     = r_d_out;

endmodule

// File: tb/tb_maze_memory.sv
// Directed bench for maze_memory: reset, loads, rat access, reload.
// Build with MAZE_ACCESS_COUNT_EN to also check the access counters.
module tb_maze_memory;

  logic        CLK;
  logic        RST;
  logic        Load_start;
  logic [15:0] row_data;
  logic        row_valid;
  logic        row_ready;
  logic        Ready;
  logic [3:0]  X;
  logic [3:0]  Y;
  logic        RD;
  logic        WR;
  logic        D_in;
  logic        D_out;
`ifdef MAZE_ACCESS_COUNT_EN
  logic [15:0] rd_count;
  logic [15:0] wr_count;
`endif

  int total = 0;
  int bad   = 0;
  int rr_hi = 0;

  maze_memory #(.N(4)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .Load_start (Load_start),
    .row_data   (row_data),
    .row_valid  (row_valid),
    .row_ready  (row_ready),
    .Ready      (Ready),
    .X          (X),
    .Y          (Y),
    .RD         (RD),
    .WR         (WR),
    .D_in       (D_in),
    .D_out      (D_out)
`ifdef MAZE_ACCESS_COUNT_EN
    ,
    .rd_count   (rd_count),
    .wr_count   (wr_count)
`endif
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [3:0] x, input logic [3:0] y);
    X  = x;
    Y  = y;
    RD = 1'b1;
    tick();
    RD = 1'b0;
  endtask

  task automatic wr(input logic [3:0] x, input logic [3:0] y,
                    input logic d);
    X    = x;
    Y    = y;
    D_in = d;
    WR   = 1'b1;
    tick();
    WR   = 1'b0;
  endtask

  task automatic pulse_load();
    Load_start = 1'b1;
    tick();
    Load_start = 1'b0;
  endtask

  initial begin
    RST        = 1'b1;
    Load_start = 1'b0;
    row_data   = '0;
    row_valid  = 1'b0;
    X          = '0;
    Y          = '0;
    RD         = 1'b0;
    WR         = 1'b0;
    D_in       = 1'b0;
    tick();
    RST = 1'b0;
    chk("rst_ready", Ready, 0);
    chk("rst_rowrdy", row_ready, 0);
    chk("rst_dout", D_out, 1);
`ifdef MAZE_ACCESS_COUNT_EN
    chk("rst_rdcnt", rd_count, 0);
    chk("rst_wrcnt", wr_count, 0);
`endif

    // premature read in IDLE sees a wall
    rd(4'd3, 4'd2);
    chk("idle_rd", D_out, 1);
    chk("idle_ready", Ready, 0);
    chk("idle_rowrdy", row_ready, 0);

    // back-to-back load, row i = 1<<i
    pulse_load();
    chk("load_ready0", Ready, 0);
    for (int i = 0; i < 16; i++) begin
      row_data  = 16'h0001 << i;
      row_valid = 1'b1;
      if (row_ready) rr_hi++;
      tick();
    end
    row_valid = 1'b0;
    chk("load_rr_cycles", rr_hi, 16);
    chk("load_done_ready", Ready, 1);
    chk("load_done_rowrdy", row_ready, 0);
    rd(4'd5, 4'd5);
    chk("diag_5_5", D_out, 1);
    rd(4'd4, 4'd5);
    chk("off_4_5", D_out, 0);
    rd(4'd15, 4'd15);
    chk("diag_15_15", D_out, 1);
    X = 4'd0;
    Y = 4'd0;
    tick();
    chk("hold_no_rd", D_out, 1);

    // rat writes
    wr(4'd7, 4'd9, 1'b1);
    rd(4'd7, 4'd9);
    chk("wr_then_rd", D_out, 1);
    X    = 4'd2;
    Y    = 4'd3;
    D_in = 1'b1;
    RD   = 1'b1;
    WR   = 1'b1;
    tick();
    RD   = 1'b0;
    WR   = 1'b0;
    chk("rbw_old", D_out, 0);
    rd(4'd2, 4'd3);
    chk("rbw_new", D_out, 1);

    // gapped load, row i = ~(1<<i)
    pulse_load();
    chk("gap_rowrdy", row_ready, 1);
    for (int i = 0; i < 16; i++) begin
      row_data  = ~(16'h0001 << i);
      row_valid = 1'b1;
      tick();
      chk("gap_ready_v", Ready, (i == 15) ? 1 : 0);
      row_valid = 1'b0;
      row_data  = 16'h0000;
      tick();
      chk("gap_rowrdy_i", row_ready, (i == 15) ? 0 : 1);
    end
    rd(4'd6, 4'd6);
    chk("gap_6_6", D_out, 0);
    rd(4'd5, 4'd6);
    chk("gap_5_6", D_out, 1);
    rd(4'd7, 4'd9);
    chk("gap_7_9", D_out, 1);
    rd(4'd9, 4'd9);
    chk("gap_9_9", D_out, 0);

    // restart after 8 junk rows, then 16 fresh rows 8000>>i
    pulse_load();
    for (int i = 0; i < 8; i++) begin
      row_data  = 16'hFFFF;
      row_valid = 1'b1;
      tick();
    end
    row_valid = 1'b0;
    chk("junk_ready", Ready, 0);
    pulse_load();
    chk("restart_rowrdy", row_ready, 1);
    for (int i = 0; i < 16; i++) begin
      row_data  = 16'h8000 >> i;
      row_valid = 1'b1;
      tick();
      row_valid = 1'b0;
      if (i == 1) begin
        X    = 4'd0;
        Y    = 4'd1;
        D_in = 1'b1;
        WR   = 1'b1;
        RD   = 1'b1;
        tick();
        WR   = 1'b0;
        RD   = 1'b0;
        chk("load_rd_wall", D_out, 1);
        chk("load_ready_mid", Ready, 0);
      end
    end
    chk("fresh_ready", Ready, 1);
    rd(4'd0, 4'd1);
    chk("load_wr_ignored", D_out, 0);
    rd(4'd14, 4'd1);
    chk("fresh_14_1", D_out, 1);
    rd(4'd15, 4'd0);
    chk("fresh_15_0", D_out, 1);
    rd(4'd0, 4'd0);
    chk("fresh_0_0", D_out, 0);
    rd(4'd8, 4'd7);
    chk("fresh_8_7", D_out, 1);
    rd(4'd9, 4'd7);
    chk("fresh_9_7", D_out, 0);
    rd(4'd0, 4'd15);
    chk("fresh_0_15", D_out, 1);

    // Load_start with RD+WR in READY
    X          = 4'd1;
    Y          = 4'd0;
    D_in       = 1'b1;
    RD         = 1'b1;
    WR         = 1'b1;
    Load_start = 1'b1;
    tick();
    RD         = 1'b0;
    WR         = 1'b0;
    Load_start = 1'b0;
    chk("ls_rd_old", D_out, 0);
    chk("ls_rowrdy", row_ready, 1);
    chk("ls_ready", Ready, 0);

    // reset mid-load
    for (int i = 0; i < 3; i++) begin
      row_data  = 16'h1234;
      row_valid = 1'b1;
      tick();
    end
    row_valid = 1'b0;
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("mid_rst_rowrdy", row_ready, 0);
    chk("mid_rst_ready", Ready, 0);
    chk("mid_rst_dout", D_out, 1);

`ifdef MAZE_ACCESS_COUNT_EN
    rd(4'd1, 4'd1);
    pulse_load();
    for (int i = 0; i < 16; i++) begin
      row_data  = 16'h0000;
      row_valid = 1'b1;
      tick();
    end
    row_valid = 1'b0;
    rd(4'd0, 4'd0);
    rd(4'd1, 4'd0);
    wr(4'd2, 4'd0, 1'b1);
    rd(4'd2, 4'd0);
    chk("cnt_rd_val", D_out, 1);
    wr(4'd3, 4'd0, 1'b1);
    chk("cnt_rd", rd_count, 3);
    chk("cnt_wr", wr_count, 2);
    pulse_load();
    chk("cnt_rd_clr", rd_count, 0);
    chk("cnt_wr_clr", wr_count, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/maze_memory.md
Name: maze_memory

Overview:
- Cell-storage responder for the maze-solving rat. It answers the rat's RD/WR cell accesses addressed by X,Y.
- It holds a 2^N x 2^N single-bit maze: 1 = wall or visited, 0 = free.
- Before solving starts, the host fills the memory one row at a time through a valid/ready row-load port.
- Sits beside the rat at top level: rat X, Y, RD, WR and D_in feed this block; this block's D_out feeds the rat's D_out input.

Parameters:
- N, 4, coordinate width. Grid is 2^N x 2^N cells (16x16 by default).
- ROWS, 2**N, row count and row width. Derived; not overridable.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RST  input  1  synchronous, active-high reset.
- Load_start  input  1  one-cycle pulse; begins a full maze load.
- row_data  input  ROWS  row contents; bit j = cell X=j of the current row.
- row_valid  input  1  host has row_data valid.
- row_ready  output  1  block accepts a row this cycle.
- Ready  output  1  maze fully loaded; rat accesses are serviced.
- X  input  N  rat column coordinate.
- Y  input  N  rat row coordinate.
- RD  input  1  rat read request.
- WR  input  1  rat write request.
- D_in  input  1  rat write data (1 = mark visited/blocked).
- D_out  output  1  registered read data to the rat.

Behaviour:
- Reset (RST=1 at an edge):
  - state=IDLE, all cells cleared to 0, row counter=0.
  - row_ready=0, Ready=0, D_out=1.
  - Reset mid-load or mid-solve abandons everything; no partial rows are kept.
- State machine:
  - IDLE -> LOAD on Load_start.
  - LOAD -> READY on acceptance of row ROWS-1.
  - READY -> LOAD on Load_start.
  - Load_start while in LOAD restarts the load at row 0; rows already written are kept until overwritten.
- LOAD:
  - row_ready=1 combinationally while in LOAD.
  - Each cycle with row_valid&row_ready: mem[row_cnt] <= row_data, row_cnt++.
  - Row 0 is Y=0. Acceptance of row ROWS-1 moves to READY at the same edge; row_ready is 0 from the next cycle.
  - row_valid outside LOAD is ignored.
- Ready: registered; 1 exactly while state=READY.
- Rat reads:
  - Condition: RD=1 at edge k in READY.
  - Response: D_out = mem[Y][X] as sampled at edge k, valid from edge k until the next read.
  - Latency 1 cycle. D_out holds its value when RD=0.
- Rat writes:
  - Condition: WR=1 at edge k in READY.
  - Effect: mem[Y][X] <= D_in at edge k.
- Simultaneous RD and WR to the same cell: read-before-write. D_out returns the pre-write value and the cell takes D_in.
- Access outside READY (IDLE or LOAD):
  - WR is ignored.
  - RD sets D_out=1 (fail-safe "wall"), so a premature rat sees walls only.
- Load_start coinciding with RD/WR in READY: state goes to LOAD; the write is still performed and the read still returns the stored value at that edge.
- No out-of-range coordinates exist; X,Y span the full grid. No wrap logic is needed.

Optional Feature:
- Macro: MAZE_ACCESS_COUNT_EN.
- When defined, adds outputs rd_count[15:0] and wr_count[15:0].
  - Each counts serviced RD and WR accesses in READY.
  - Both clear on RST and on Load_start.
  - Both saturate at 16'hFFFF rather than wrapping.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Reset, then RD with X=3,Y=2 -> D_out=1 next cycle, Ready=0, row_ready=0.
- Load_start, 16 back-to-back rows with row i = 16'h0001<<i -> row_ready high 16 cycles, Ready=1 after 16th acceptance. RD at (5,5) -> 1; RD at (4,5) -> 0.
- Load with row_valid toggled 1,0,1,0 -> only the valid cycles advance the row counter; Ready rises after exactly 16 accepted rows.
- In READY, WR D_in=1 at (7,9), then RD (7,9) -> D_out=1. Same-cycle RD+WR D_in=1 at a free cell -> D_out=0, and a following RD -> 1.
- Load_start at the 8th accepted row, then 16 fresh rows -> final contents equal the fresh rows only; WR pulses during LOAD leave cells unchanged.
- With MAZE_ACCESS_COUNT_EN: 3 reads + 2 writes in READY plus 1 read in IDLE -> rd_count=3, wr_count=2; Load_start -> both 0.
